// File: rtl/text_console_if.sv
// Character-stream handshake, status and screen-memory write port for text_console.
interface text_console_if;
   logic        in_valid;
   logic [7:0]  in_code;
   logic        in_ready;
   logic        clear;
   logic        busy;
   logic [10:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [5:0]  cursor_col;
   logic [4:0]  cursor_row;

   modport master (
      output in_valid, in_code, clear, mem_rdata,
      input  in_ready, busy, mem_addr, mem_we, mem_wdata, cursor_col, cursor_row
   );

   modport slave (
      input  in_valid, in_code, clear, mem_rdata,
      output in_ready, busy, mem_addr, mem_we, mem_wdata, cursor_col, cursor_row
   );
endinterface

// File: rtl/text_console.sv
// Writes a character stream into the 40x30 screen memory, tracking a cursor,
// scrolling up one row on bottom overflow and clearing the screen on request.
module text_console (
   input logic           clk,
   input logic           rst_n,
   text_console_if.slave bus
);
   localparam logic [5:0]  LAST_COL  = 6'd39;
   localparam logic [4:0]  LAST_ROW  = 5'd29;
   localparam logic [10:0] ROW_STEP  = 11'd40;
   localparam logic [10:0] LAST_MOVE = 11'd1159;
   localparam logic [10:0] LAST_CELL = 11'd1199;
   localparam logic [7:0]  BLANK     = 8'h20;
   localparam logic [7:0]  C_LF      = 8'h0A;
   localparam logic [7:0]  C_CR      = 8'h0D;
   localparam logic [7:0]  C_BS      = 8'h08;

   typedef enum logic [2:0] {IDLE, SLOT, SCROLL_RD, SCROLL_WR, SCROLL_BLANK, CLEAR} state_t;
   typedef struct packed {
      logic [4:0] row;
      logic [5:0] col;
   } cursor_t;

   state_t      state;
   cursor_t     cur, nxt;
   logic [10:0] idx, cur_addr, mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we, pend_clr, clr_go;
   logic        printable, advance, scroll, scrolling;

   // row*40 + col as two shifted copies of row plus col
   assign cur_addr = {1'b0, cur.row, 5'd0} + {3'd0, cur.row, 3'd0} + {5'd0, cur.col};

   assign scrolling = (state == SLOT) || (state == SCROLL_RD) ||
                      (state == SCROLL_WR) || (state == SCROLL_BLANK);
   assign clr_go    = pend_clr | bus.clear;

   always_comb begin
      nxt       = cur;
      advance   = 1'b0;
      printable = 1'b0;
      case (bus.in_code)
         C_LF: begin
            nxt.col = '0;
            advance = 1'b1;
         end
         C_CR: nxt.col = '0;
         C_BS: if (cur.col != 6'd0) nxt.col = cur.col - 6'd1;
         default: begin
            printable = 1'b1;
            if (cur.col == LAST_COL) begin
               nxt.col = '0;
               advance = 1'b1;
            end else begin
               nxt.col = cur.col + 6'd1;
            end
         end
      endcase
      // advancing off the bottom row keeps the row and scrolls instead
      scroll = advance && (cur.row == LAST_ROW);
      if (advance && !scroll) nxt.row = cur.row + 5'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur       <= '0;
         idx       <= '0;
         pend_clr  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         if (scrolling) pend_clr <= clr_go;
         case (state)
            IDLE: begin
               if (bus.clear) begin
                  state     <= CLEAR;
                  cur       <= '0;
                  idx       <= '0;
                  mem_addr  <= '0;
                  mem_wdata <= BLANK;
                  mem_we    <= 1'b1;
               end else if (bus.in_valid) begin
                  cur       <= nxt;
                  mem_addr  <= cur_addr;
                  mem_wdata <= bus.in_code;
                  mem_we    <= printable;
                  if (scroll) state <= SLOT;
               end
            end
            SLOT: begin
               idx      <= '0;
               mem_addr <= ROW_STEP;
               state    <= SCROLL_RD;
            end
            SCROLL_RD: begin
               // read data is combinational, so the copy is held in mem_wdata
               mem_wdata <= bus.mem_rdata;
               mem_addr  <= idx;
               mem_we    <= 1'b1;
               state     <= SCROLL_WR;
            end
            SCROLL_WR: begin
               idx <= idx + 11'd1;
               if (idx == LAST_MOVE) begin
                  mem_addr  <= idx + 11'd1;
                  mem_wdata <= BLANK;
                  mem_we    <= 1'b1;
                  state     <= SCROLL_BLANK;
               end else begin
                  mem_addr <= idx + ROW_STEP + 11'd1;
                  state    <= SCROLL_RD;
               end
            end
            SCROLL_BLANK: begin
               if (idx != LAST_CELL) begin
                  idx      <= idx + 11'd1;
                  mem_addr <= idx + 11'd1;
                  mem_we   <= 1'b1;
               end else if (clr_go) begin
                  state     <= CLEAR;
                  cur       <= '0;
                  idx       <= '0;
                  pend_clr  <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= BLANK;
                  mem_we    <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            CLEAR: begin
               if (idx != LAST_CELL) begin
                  idx      <= idx + 11'd1;
                  mem_addr <= idx + 11'd1;
                  mem_we   <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state == IDLE) && !bus.clear;
   assign bus.busy       = (state != IDLE);
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_we     = mem_we;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.cursor_col = cur.col;
   assign bus.cursor_row = cur.row;
endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: screen memory model, write scoreboard,
// cursor/timing checks for chars, control codes, scroll, clear and reset.
module tb_text_console;
   typedef struct packed {
      logic [10:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       pre_en = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         acc_cnt = 0;
   int         mcol = 0;
   int         mrow = 0;
   logic [7:0] mem     [1200];
   logic [7:0] ref_mem [1200];
   wr_t        exp_q [$];

   text_console_if bus ();
   text_console dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   assign bus.mem_rdata = (bus.mem_addr < 11'd1200) ? mem[bus.mem_addr] : 8'h00;

   always @(posedge clk) begin
      if (pre_en) begin
         for (int k = 0; k < 1200; k++) mem[k] <= 8'(k / 40);
      end else if (bus.mem_we === 1'b1 && bus.mem_addr < 11'd1200) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   always @(posedge clk)
      if (rst_n && bus.in_valid && bus.in_ready) acc_cnt++;

   // every observed write must be the next expected one, in order
   always @(negedge clk) begin
      wr_t got, e;
      if (rst_n && bus.mem_we === 1'b1) begin
         got.addr = bus.mem_addr;
         got.data = bus.mem_wdata;
         if (exp_q.size() == 0) e = '1;
         else e = exp_q.pop_front();
         checks++;
         assert (got === e) else begin
            errors++;
            $error("FAIL wr observed %0d:%0h expected %0d:%0h", got.addr, got.data, e.addr, e.data);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cur(input int c, input int r);
      chk("cursor_col", 32'(bus.cursor_col), 32'(c));
      chk("cursor_row", 32'(bus.cursor_row), 32'(r));
   endtask

   function automatic int count_ne(input logic [7:0] v, input int lo, input int hi);
      int c;
      c = 0;
      for (int k = lo; k <= hi; k++) if (mem[k] !== v) c++;
      return c;
   endfunction

   task automatic push_scroll();
      for (int i = 0; i < 1200; i++) begin
         wr_t w;
         w.addr = 11'(i);
         w.data = (i < 1160) ? ref_mem[i + 40] : 8'h20;
         exp_q.push_back(w);
         ref_mem[i] = w.data;
      end
   endtask

   task automatic push_clear();
      for (int i = 0; i < 1200; i++) begin
         wr_t w;
         w.addr = 11'(i);
         w.data = 8'h20;
         exp_q.push_back(w);
         ref_mem[i] = 8'h20;
      end
      mcol = 0;
      mrow = 0;
   endtask

   task automatic preload();
      pre_en = 1'b1;
      @(negedge clk);
      pre_en = 1'b0;
      for (int k = 0; k < 1200; k++) ref_mem[k] = 8'(k / 40);
   endtask

   // drive one code for one cycle starting at a negedge
   task automatic send(input logic [7:0] c);
      logic adv;
      adv = 1'b0;
      chk("ready_at_send", 32'(bus.in_ready), 32'd1);
      case (c)
         8'h0A: begin
            mcol = 0;
            adv  = 1'b1;
         end
         8'h0D: mcol = 0;
         8'h08: if (mcol > 0) mcol--;
         default: begin
            wr_t w;
            w.addr = 11'(mrow * 40 + mcol);
            w.data = c;
            exp_q.push_back(w);
            ref_mem[mrow * 40 + mcol] = c;
            if (mcol == 39) begin
               mcol = 0;
               adv  = 1'b1;
            end else begin
               mcol++;
            end
         end
      endcase
      if (adv) begin
         if (mrow < 29) mrow++;
         else push_scroll();
      end
      bus.in_valid = 1'b1;
      bus.in_code  = c;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic count_busy(input int limit, output int n, output logic rdy);
      n   = 0;
      rdy = 1'b0;
      while (bus.busy === 1'b1 && n < limit) begin
         rdy = rdy | bus.in_ready;
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int   n, a0;
      logic rdy;
      bus.in_valid = 1'b0;
      bus.in_code  = 8'h00;
      bus.clear    = 1'b0;

      // reset state
      #2 rst_n = 1'b0;
      #2;
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk_cur(0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);

      // single printable
      send(8'h41);
      chk_cur(1, 0);
      chk("ready_after_a", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      chk("mem0", 32'(mem[0]), 32'h41);

      // 40 back-to-back wraps to next row
      send(8'h0D);
      chk_cur(0, 0);
      a0 = acc_cnt;
      repeat (40) send(8'h42);
      chk("acc40", 32'(acc_cnt - a0), 32'd40);
      chk_cur(0, 1);
      @(negedge clk);
      chk("row0_42", 32'(count_ne(8'h42, 0, 39)), 32'd0);

      // backspace / carriage return
      send(8'h0A);
      send(8'h0A);
      chk_cur(0, 3);
      send(8'h08);
      chk("bs_no_we", 32'(bus.mem_we), 32'd0);
      chk_cur(0, 3);
      repeat (7) send(8'h43);
      chk_cur(7, 3);
      send(8'h08);
      chk_cur(6, 3);
      send(8'h43);
      send(8'h0D);
      chk_cur(0, 3);

      // scroll from (5,29)
      repeat (26) send(8'h0A);
      chk_cur(0, 29);
      repeat (5) send(8'h44);
      chk_cur(5, 29);
      @(negedge clk);
      preload();
      send(8'h0A);
      count_busy(5000, n, rdy);
      chk("scroll_busy", 32'(n), 32'd2361);
      chk("scroll_ready_low", 32'(rdy), 32'd0);
      chk("scroll_ready_after", 32'(bus.in_ready), 32'd1);
      chk_cur(0, 29);
      chk("scroll_q_empty", 32'(exp_q.size()), 32'd0);
      for (int r = 0; r < 29; r++)
         chk("scroll_row", 32'(count_ne(8'(r + 1), r * 40, r * 40 + 39)), 32'd0);
      chk("scroll_blank_row", 32'(count_ne(8'h20, 1160, 1199)), 32'd0);

      // clear wins over simultaneous in_valid
      bus.clear    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_code  = 8'h45;
      a0 = acc_cnt;
      #1;
      chk("clr_ready_low", 32'(bus.in_ready), 32'd0);
      push_clear();
      @(negedge clk);
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      chk("clr_no_accept", 32'(acc_cnt - a0), 32'd0);
      chk_cur(0, 0);
      count_busy(5000, n, rdy);
      chk("clr_busy", 32'(n), 32'd1200);
      chk("clr_ready_after", 32'(bus.in_ready), 32'd1);
      chk("clr_q_empty", 32'(exp_q.size()), 32'd0);
      chk("clr_all_blank", 32'(count_ne(8'h20, 0, 1199)), 32'd0);

      // reset in the middle of a scroll
      repeat (29) send(8'h0A);
      chk_cur(0, 29);
      send(8'h0A);
      repeat (500) @(negedge clk);
      chk("we_before_rst", 32'(bus.mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("we_in_rst", 32'(bus.mem_we), 32'd0);
      chk("busy_in_rst", 32'(bus.busy), 32'd0);
      chk_cur(0, 0);
      exp_q.delete();
      mcol = 0;
      mrow = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 32'(bus.in_ready), 32'd1);
      chk("rel_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);

      // clear requested mid-scroll runs straight after the blank row
      repeat (29) send(8'h0A);
      preload();
      send(8'h0A);
      push_clear();
      a0 = acc_cnt;
      bus.in_valid = 1'b1;
      bus.in_code  = 8'h46;
      n   = 0;
      rdy = 1'b0;
      while (bus.busy === 1'b1 && n < 8000) begin
         bus.clear = (n == 100) ? 1'b1 : 1'b0;
         rdy = rdy | bus.in_ready;
         n++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
      chk("pend_busy", 32'(n), 32'd3561);
      chk("pend_ready_low", 32'(rdy), 32'd0);
      chk("pend_no_accept", 32'(acc_cnt - a0), 32'd0);
      chk_cur(0, 0);
      chk("pend_ready_after", 32'(bus.in_ready), 32'd1);
      chk("pend_q_empty", 32'(exp_q.size()), 32'd0);
      chk("pend_all_blank", 32'(count_ne(8'h20, 0, 1199)), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/text_console.md
# text_console

Character-stream writer for the 40×30 text screen memory. Accepts 8-bit character codes over a valid/ready handshake and maintains a cursor. It writes printable codes into the memory's write port (address, write enable, write data, combinational read data) and interprets control codes. On bottom-row overflow it scrolls the screen up one row by read-copy-write, and it clears the whole screen on request. It sits between the command/CPU logic and the screen memory; the VGA side of the memory is untouched.

## Interface
- COLS, 40, characters per row
- ROWS, 30, rows per screen
- BLANK, 8'h20, code written by scroll and clear
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_code is valid
- in_code  in  8  character or control code
- in_ready  out  1  block accepts in_code this cycle
- clear  in  1  request full-screen clear (level sampled in IDLE)
- busy  out  1  scroll or clear in progress
- mem_addr  out  11  memory address (row*40+col)
- mem_we  out  1  memory write enable (written at rising edge)
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data for mem_addr, combinational
- cursor_col  out  6  current column, 0..39
- cursor_row  out  5  current row, 0..29

## Operation
- States: IDLE, SLOT, SCROLL_RD, SCROLL_WR, SCROLL_BLANK, CLEAR.
- in_ready = (state==IDLE) && !clear. Accept = in_valid && in_ready at a rising edge.
- Codes on accept:
  - 0x0A: col←0, row+1.
  - 0x0D: col←0.
  - 0x08: col−1 if col>0, else no change; nothing written.
  - Any other code: write the code at the pre-accept cursor, then col+1. At col 39, col←0 and row+1.
- Row advance from row 29 keeps row at 29 and triggers a scroll. Next state is SLOT, then SCROLL_RD.
- Accept without scroll keeps the state in IDLE. Back-to-back accepts give 1 code/cycle.
- Char write is registered: the cycle after accept drives mem_we=1, mem_addr = old cursor, mem_wdata = code. Control codes drive mem_we=0 in that cycle.
- Scroll uses a linear index i = 0..1159:
  - SCROLL_RD: mem_addr=i+40, capture mem_rdata.
  - SCROLL_WR: mem_addr=i, mem_we=1, mem_wdata=captured value, then i+1.
  - SCROLL_BLANK: i=1160..1199, one write of BLANK per cycle.
  - Then IDLE.
- Clear: in IDLE with clear=1, go to CLEAR. Cursor←(0,0) at that edge. Write BLANK to addresses 0..1199, one per cycle, then IDLE.
- clear during busy is latched as pending. Pending clear starts CLEAR on the cycle the scroll would return to IDLE; no input is accepted in between.
- Simultaneous clear and in_valid in IDLE: clear wins and in_code is not accepted.
- Address arithmetic: row*40 = (row<<5)+(row<<3), 11-bit, max 1199. Addresses ≥1200 are never driven.
- busy=1 in SCROLL_*, CLEAR, and SLOT when a scroll follows.

## Timing
- Reset values (asynchronous, rst_n low):
  - state IDLE, cursor (0,0), busy 0, in_ready 1 after release.
  - mem_we 0, mem_addr 0, mem_wdata 0, pending clear 0, scroll index 0.
- Reset mid-scroll or mid-clear: mem_we drops immediately and the operation is abandoned. Partially moved contents remain.
- Char write latency: accepted at edge N, memory updated at edge N+1.
- Scroll from accept edge N:
  - SLOT in cycle N+1.
  - SCROLL_RD/WR pairs in cycles N+2..N+2321.
  - BLANK in cycles N+2322..N+2361.
  - in_ready high in cycle N+2362.
- Clear from edge N: writes in cycles N+1..N+1200. in_ready high in cycle N+1201 if clear is deasserted.
- Outputs mem_* and cursor are registered. in_ready is combinational from state and clear only.

## Test plan
- Reset, send 0x41 → addr 0 = 0x41 one edge after accept; cursor (1,0); in_ready stays 1.
- From (0,0), send 40 × 0x42 back-to-back → addrs 0..39 = 0x42; cursor (0,1); 40 accepts in 40 cycles.
- Preload row r with code r. Set cursor (5,29), send 0x0A → busy for 2361 cycles. Then row r holds code r+1 for r=0..28, row 29 = 0x20, cursor (0,29).
- Pulse clear with in_valid=1 simultaneously → in_code not accepted; 1200 writes of 0x20; cursor (0,0); in_ready back after 1200 cycles.
- Cursor (0,3): send 0x08 → no write, cursor (0,3). Then send 0x0D at (7,3) → cursor (0,3).
- Assert rst_n=0 at scroll cycle 500 → mem_we=0 within the same cycle; after release cursor (0,0), busy 0, in_ready 1. Pending clear issued during scroll runs immediately after BLANK.
